// File: rtl/sum_seq_pkg.sv
// Shared widths, state encoding and the double-dabble digit adjust used by
// the sum sequencer and its serial binary-to-BCD converter.
package sum_seq_pkg;

    localparam int OPERAND_W   = 10;
    localparam int SUM_W       = 11;
    localparam int BCD_DIGITS  = 4;
    localparam int CONV_ITER   = 11;
    localparam int MAX_OPERAND = 999;
    localparam int BCD_W       = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CONV = 2'd2,
        SHOW = 2'd3
    } state_t;

    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one adjust-and-shift per cycle after start.
// bcd_o carries the value being committed this cycle, so it is final while done is high.
module bin2bcd_serial
    import sum_seq_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             abort,
    input  logic             start,
    input  logic [SUM_W-1:0] bin_i,
    output logic             done,
    output logic [BCD_W-1:0] bcd_o
);

    logic [SUM_W-1:0]       bin_q, bin_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [3:0]             iter_q, iter_d;
    logic                   run_q, run_d;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+SUM_W-1:0] shifted;

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = dabble_adj(bcd_q[gi*4 +: 4]);
    end

    assign shifted = {bcd_adj, bin_q} << 1;
    assign bcd_o   = shifted[BCD_W+SUM_W-1:SUM_W];
    assign done    = run_q && (iter_q == 4'(CONV_ITER - 1));

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        iter_d = iter_q;
        run_d  = run_q;
        if (abort) begin
            run_d  = 1'b0;
            iter_d = '0;
        end else if (start) begin
            bin_d  = bin_i;
            bcd_d  = '0;
            iter_d = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            bcd_d = shifted[BCD_W+SUM_W-1:SUM_W];
            bin_d = shifted[SUM_W-1:0];
            if (done) begin
                run_d  = 1'b0;
                iter_d = '0;
            end else begin
                iter_d = iter_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            iter_q <= iter_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/sum_sequencer.sv
// Adds two keypad operands, converts the sum to BCD serially and multiplexes
// the digits onto a 4-digit display with leading-zero blanking.
module sum_sequencer
    import sum_seq_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Sum_ready,
    input  logic [OPERAND_W-1:0]  Num1_value,
    input  logic [OPERAND_W-1:0]  Num2_value,
    input  logic                  Clear_req,
    output logic                  Reader_clr,
    output logic                  Busy,
    output logic                  Result_valid,
    output logic                  Input_err,
    output logic [SUM_W-1:0]      Result_bin,
    output logic [BCD_W-1:0]      Bcd_digits,
    output logic [BCD_DIGITS-1:0] Anode,
    output logic [3:0]            Seg_digit
);

    localparam int RW = $clog2(REFRESH_DIV);

    state_t           state_q, state_d;
    logic             sum_ready_q, sum_ready_d;
    logic             sr_armed_q, sr_armed_d;
    logic             clear_q, clear_d;
    logic             reader_clr_q, reader_clr_d;
    logic             input_err_q, input_err_d;
    logic [SUM_W-1:0] result_bin_q, result_bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [RW-1:0]    refresh_q, refresh_d;
    logic [1:0]       digit_idx_q, digit_idx_d;

    logic             sr_rise, clr_rise, conv_start, conv_done;
    logic [SUM_W-1:0] sum_now;
    logic [BCD_W-1:0] conv_bcd;
    logic [BCD_DIGITS-1:0] upper_zero;
    logic             blank;

    // A Sum_ready level held through reset must drop before it may start a conversion.
    assign sr_rise  = Sum_ready && !sum_ready_q && sr_armed_q;
    assign clr_rise = Clear_req && !clear_q;
    assign sum_now  = SUM_W'(Num1_value) + SUM_W'(Num2_value);

    bin2bcd_serial u_conv (
        .clk   (Clock),
        .srst  (Reset),
        .abort (Clear_req),
        .start (conv_start),
        .bin_i (sum_now),
        .done  (conv_done),
        .bcd_o (conv_bcd)
    );

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (Clear_req) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (sr_rise) state_d = LOAD;
                LOAD:    state_d = CONV;
                CONV:    if (conv_done) state_d = SHOW;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        sum_ready_d  = Sum_ready;
        sr_armed_d   = sr_armed_q || !Sum_ready;
        clear_d      = Clear_req;
        reader_clr_d = clr_rise;
        input_err_d  = input_err_q;
        result_bin_d = result_bin_q;
        bcd_d        = bcd_q;
        conv_start   = 1'b0;
        if (Clear_req) begin
            input_err_d  = 1'b0;
            result_bin_d = '0;
            bcd_d        = '0;
        end else if (state_q == LOAD) begin
            result_bin_d = sum_now;
            input_err_d  = (Num1_value > OPERAND_W'(MAX_OPERAND)) ||
                           (Num2_value > OPERAND_W'(MAX_OPERAND));
            bcd_d        = '0;
            conv_start   = 1'b1;
        end else if (state_q == CONV && conv_done) begin
            bcd_d = input_err_q ? '1 : conv_bcd;
        end

        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d   = '0;
            digit_idx_d = digit_idx_q + 2'd1;
        end else begin
            refresh_d   = refresh_q + RW'(1);
            digit_idx_d = digit_idx_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sum_ready_q  <= 1'b0;
            sr_armed_q   <= !Sum_ready;
            clear_q      <= 1'b0;
            reader_clr_q <= 1'b0;
            input_err_q  <= 1'b0;
            result_bin_q <= '0;
            bcd_q        <= '0;
            refresh_q    <= '0;
            digit_idx_q  <= '0;
        end else begin
            sum_ready_q  <= sum_ready_d;
            sr_armed_q   <= sr_armed_d;
            clear_q      <= clear_d;
            reader_clr_q <= reader_clr_d;
            input_err_q  <= input_err_d;
            result_bin_q <= result_bin_d;
            bcd_q        <= bcd_d;
            refresh_q    <= refresh_d;
            digit_idx_q  <= digit_idx_d;
        end
    end

    // upper_zero[gi]: this nibble and every nibble above it are zero.
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_blank
        assign upper_zero[gi] = (bcd_q[BCD_W-1:gi*4] == '0);
    end

    assign blank = !input_err_q && (digit_idx_q != 2'd0) && upper_zero[digit_idx_q];

    always_comb begin
        Busy         = (state_q == LOAD) || (state_q == CONV);
        Result_valid = (state_q == SHOW);
        Anode        = '0;
        Seg_digit    = 4'h0;
        if (state_q == SHOW) begin
            Seg_digit = bcd_q[{digit_idx_q, 2'b00} +: 4];
            if (!blank) Anode = BCD_DIGITS'(1) << digit_idx_q;
        end
    end

    assign Reader_clr = reader_clr_q;
    assign Input_err  = input_err_q;
    assign Result_bin = result_bin_q;
    assign Bcd_digits = bcd_q;

endmodule
